// File: rtl/pipe_hazard_unit_if.sv
// Bundle of ID-stage, result-bus and writeback signals between the pipeline
// control (master) and pipe_hazard_unit (slave).
interface pipe_hazard_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16
);
    logic                    id_valid;
    logic [REG_AW-1:0]       id_rs;
    logic [REG_AW-1:0]       id_rt;
    logic                    id_rs_used;
    logic                    id_rt_used;
    logic                    id_wen;
    logic [REG_AW-1:0]       id_rd;
    logic                    flush;
    logic [DATA_W-1:0]       rf_a;
    logic [DATA_W-1:0]       rf_b;
    logic [DEPTH*DATA_W-1:0] res_data;
    logic [DEPTH-1:0]        res_ready;
    logic                    id_stall;
    logic [DATA_W-1:0]       opa;
    logic [DATA_W-1:0]       opb;
    logic                    wb_wen;
    logic [REG_AW-1:0]       wb_rd;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_rd,
        output flush, rf_a, rf_b, res_data, res_ready,
        input  id_stall, opa, opb, wb_wen, wb_rd, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_rd,
        input  flush, rf_a, rf_b, res_data, res_ready,
        output id_stall, opa, opb, wb_wen, wb_rd, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard / stall / operand-forwarding unit for the in-order pipeline.
// Destination tags of issued instructions travel down a shift register from
// EX (stage 0) to WB (stage DEPTH-1); ID sources are compared against it.
// Define PIPE_HAZARD_FORWARD_EN to forward ready results from res_data and
// stall only on not-yet-ready producers; otherwise any in-flight producer
// stalls ID and operands always come from the register file.
module pipe_hazard_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned CNT_W  = 16
) (
    input logic            clk,
    input logic            rst,
    pipe_hazard_unit_if.slave bus
);

    logic [DEPTH-1:0]  tag_v;
    logic [REG_AW-1:0] tag_rd [DEPTH];
    logic [CNT_W-1:0]  cnt;

    logic              hit_a;
    logic              hit_b;
    logic              stall;
    logic              issue_v;

`ifdef PIPE_HAZARD_FORWARD_EN
    logic              rdy_a;
    logic              rdy_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        fwd_a = '0;
        fwd_b = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            int unsigned i;
            i = DEPTH - 1 - j;
            if (bus.id_rs_used && (bus.id_rs != '0) && tag_v[i] &&
                (tag_rd[i] == bus.id_rs)) begin
                hit_a = 1'b1;
                rdy_a = bus.res_ready[i];
                fwd_a = bus.res_data[i*DATA_W +: DATA_W];
            end
            if (bus.id_rt_used && (bus.id_rt != '0) && tag_v[i] &&
                (tag_rd[i] == bus.id_rt)) begin
                hit_b = 1'b1;
                rdy_b = bus.res_ready[i];
                fwd_b = bus.res_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stall only while the youngest producer has no result yet.
    always_comb begin
        stall   = bus.id_valid & ((hit_a & ~rdy_a) | (hit_b & ~rdy_b));
        bus.opa = hit_a ? fwd_a : bus.rf_a;
        bus.opb = hit_b ? fwd_b : bus.rf_b;
    end
`else
    logic unused_res;
    assign unused_res = ^{bus.res_data, bus.res_ready};

    // Any in-flight producer of a used source is a hazard.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (bus.id_rs_used && (bus.id_rs != '0) && tag_v[i] &&
                (tag_rd[i] == bus.id_rs)) begin
                hit_a = 1'b1;
            end
            if (bus.id_rt_used && (bus.id_rt != '0) && tag_v[i] &&
                (tag_rd[i] == bus.id_rt)) begin
                hit_b = 1'b1;
            end
        end
    end

    // Without forwarding the register file is the only operand source.
    always_comb begin
        stall   = bus.id_valid & (hit_a | hit_b);
        bus.opa = bus.rf_a;
        bus.opb = bus.rf_b;
    end
`endif

    assign issue_v = bus.id_valid & ~stall & ~bus.flush & bus.id_wen &
                     (bus.id_rd != '0);

    // Tag shift register: a new tag enters EX, older tags advance toward WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_rd[i] <= '0;
            end
        end else begin
            tag_v[0]  <= issue_v;
            tag_rd[0] <= bus.id_rd;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_rd[i] <= tag_rd[i-1];
            end
        end
    end

    // Saturating count of ID cycles lost to hazards; flushed cycles excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.id_valid && stall && !bus.flush && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bus.id_stall  = stall;
    assign bus.wb_wen    = tag_v[DEPTH-1];
    assign bus.wb_rd     = tag_rd[DEPTH-1];
    assign bus.stall_cnt = cnt;

endmodule
